gb_apu_wave_channel_param: RTL
==============================

// Module: gb_apu_wave_channel_param
// PURPOSE
//  Parametrised wave channel (APU channel 3 class). Holds its own wave RAM with a CPU byte port.
//  Plays NUM_SAMPLES samples of SAMPLE_W bits at a programmable rate, in loop or one-shot mode.
//  Applies the length function and volume shift internally; level feeds the APU mixer.
// PARAMETERS
//  SAMPLE_W     4   sample width; legal values 4 or 8 (samples per byte SPB = 8/SAMPLE_W)
//  NUM_SAMPLES  32  wave length; power of 2, >= SPB; byte count NB = NUM_SAMPLES/SPB
//  FREQ_W       11  width of the period value
//  DIV_SHIFT    1   divider pre-scale; the step period is 2^DIV_SHIFT*(2^FREQ_W - frequency) clk
//  LENGTH_W     8   width of the length value
// PORTS
//  clk             in   1                     system clock
//  reset           in   1                     asynchronous, active-high reset
//  clk_length_ctr  in   1                     length tick; its rising edge is detected on clk
//  start           in   1                     trigger; its rising edge is detected on clk
//  dac_on          in   1                     channel DAC power; low forces the channel off
//  single          in   1                     length function enable
//  one_shot        in   1                     1 = stop after the last sample; 0 = loop
//  length          in   LENGTH_W              length load value
//  volume          in   2                     00 mute, 01 100%, 10 50%, 11 25%
//  frequency       in   FREQ_W                period value
//  cpu_we          in   1                     wave RAM write strobe
//  cpu_addr        in   $clog2(NB)            wave RAM byte address
//  cpu_wdata       in   8                     write data
//  cpu_rdata       out  8                     read data (combinational)
//  position        out  $clog2(NUM_SAMPLES)   current sample pointer
//  level           out  SAMPLE_W              output audio level
//  enable          out  1                     channel active flag
// BEHAVIOUR
//  Reset: all state is cleared, including the wave RAM, sample_buf, the divider, length counter and edge regs.
//   Outputs after reset: level=0, enable=0, position=0, cpu_rdata=0.
//  Trigger (trig) = start & ~start_q. On trig:
//   - active <= dac_on
//   - pointer <= 0
//   - divider <= {frequency, DIV_SHIFT'b0}
//   - len_cnt (LENGTH_W+1 bits) <= 2^LENGTH_W - length
//   - sample_buf is unchanged (stale-sample quirk)
//  Divider: counts only while active, +1 per clk. When it reaches all-ones it reloads {frequency,0s} and takes a step.
//  Step:
//   - pointer <= pointer+1, wrapping NUM_SAMPLES-1 -> 0
//   - sample_buf <= RAM sample at the new pointer; the first step after trig therefore loads sample 1
//   - if one_shot and pointer was NUM_SAMPLES-1: pointer wraps to 0 and active <= 0
//  Sample mapping: sample i sits in byte i/SPB. For SAMPLE_W=4, even i is bits[7:4] and odd i is bits[3:0].
//  Length: on a clk_length_ctr rising edge with single & active, len_cnt decrements.
//   When the decrement makes len_cnt 0, active <= 0. length=0 gives 2^LENGTH_W ticks.
//  dac_on low: active <= 0 on the next clk edge.
//  enable = active.
//  level:
//   - 0 if !active, !dac_on or volume=00
//   - otherwise sample_buf >> (volume-1) (shift 0, 1 or 2), zero-filled
//  CPU port:
//   - while active, writes are ignored and cpu_rdata = 8'hFF
//   - while inactive, a write lands at the clk edge and cpu_rdata = RAM[cpu_addr]
//   - the gating uses the registered active flag
//  Precedence and simultaneous events:
//   - trig beats step, length tick and one-shot stop in the same cycle
//   - a cpu_we in the trig cycle is accepted if active was 0 before that cycle
//   - dac_on low beats trig (the channel stays off, but pointer/divider/len_cnt still load)
//   - reset mid-playback returns everything to reset values immediately
// TESTING
//  1. Reset, write bytes 0..15 = 8'h01,8'h23..8'hEF, trig, frequency=2047, volume=01.
//     -> steps every 2 clk; level sequence 1,2,3..F,0,1..; position wraps 31->0.
//  2. While active, cpu_we addr 3 data 8'hAA.
//     -> cpu_rdata=FF; after the channel stops, RAM[3] still reads 8'h67.
//  3. single=1, length=254, trig.
//     -> enable drops on the 2nd clk_length_ctr rising edge; level=0 afterward.
//  4. one_shot=1, frequency=2047, trig.
//     -> enable falls in the cycle after the step from pointer 31; position=0.
//  5. Sample 5 = 4'hC: volume 01/10/11/00 -> level C/6/3/0. dac_on=0 -> level 0 and enable 0 the next clk.
//  6. Trig asserted in the same cycle as a divider overflow.
//     -> pointer=0, divider reloaded, no step. Reset mid-play -> all outputs 0 immediately.

Source files
------------

// File: rtl/gb_apu_wave_channel_param.sv
// Wave channel: private wave RAM with CPU byte port,
// programmable-rate sample playback, length timer and volume shift.
module gb_apu_wave_channel_param #(
  parameter int SAMPLE_W    = 4,
  parameter int NUM_SAMPLES = 32,
  parameter int FREQ_W      = 11,
  parameter int DIV_SHIFT   = 1,
  parameter int LENGTH_W    = 8,
  localparam int SPB = 8 / SAMPLE_W,
  localparam int NB  = NUM_SAMPLES / SPB,
  localparam int AW  = $clog2(NB),
  localparam int PW  = $clog2(NUM_SAMPLES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_length_ctr,
  input  logic                start,
  input  logic                dac_on,
  input  logic                single,
  input  logic                one_shot,
  input  logic [LENGTH_W-1:0] length,
  input  logic [1:0]          volume,
  input  logic [FREQ_W-1:0]   frequency,
  input  logic                cpu_we,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [7:0]          cpu_wdata,
  output logic [7:0]          cpu_rdata,
  output logic [PW-1:0]       position,
  output logic [SAMPLE_W-1:0] level,
  output logic                enable
);

  localparam int DW = FREQ_W + DIV_SHIFT;
  localparam int CW = LENGTH_W + 1;
  localparam int SB = $clog2(SPB);

  logic [7:0]          ram [NB];
  logic                start_q;
  logic                lctr_q;
  logic                active;
  logic                active_nxt;
  logic [PW-1:0]       ptr;
  logic [DW-1:0]       div;
  logic [CW-1:0]       len_cnt;
  logic [SAMPLE_W-1:0] sample_buf;
  logic [SAMPLE_W-1:0] new_sample;
  logic [7:0]          fetch_byte;
  logic [3:0]          shamt;
  logic [1:0]          vshift;

  logic          trig;
  logic          len_tick;
  logic          step;
  logic          len_dec;
  logic          last;
  logic [PW-1:0] nxt_ptr;
  logic [DW-1:0] reload;
  logic [CW-1:0] len_load;
  logic [AW-1:0] byte_idx;

  assign trig     = start & ~start_q;
  assign len_tick = clk_length_ctr & ~lctr_q;
  assign reload   = DW'(frequency) << DIV_SHIFT;
  assign len_load = {1'b1, {LENGTH_W{1'b0}}}
                  - {1'b0, length};
  assign step     = active & ~trig & (&div);
  assign nxt_ptr  = ptr + 1'b1;
  assign last     = (ptr == PW'(NUM_SAMPLES - 1));
  assign len_dec  = len_tick & single & active
                  & ~trig & (len_cnt != '0);
  assign byte_idx = AW'(nxt_ptr >> SB);

  // Pick the sample at the next pointer out of its byte
  always_comb begin
    fetch_byte = ram[byte_idx];
    shamt = 4'(((SPB - 1) - (int'(nxt_ptr) % SPB)) * SAMPLE_W);
    new_sample = SAMPLE_W'(fetch_byte >> shamt);
  end

  // Next active flag; dac_on low overrides everything
  always_comb begin
    active_nxt = active;
    if (trig) begin
      active_nxt = 1'b1;
    end else begin
      if (step && one_shot && last)
        active_nxt = 1'b0;
      if (len_dec && len_cnt == CW'(1))
        active_nxt = 1'b0;
    end
    if (!dac_on)
      active_nxt = 1'b0;
  end

  // Edge detect registers and active flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      lctr_q  <= 1'b0;
      active  <= 1'b0;
    end else begin
      start_q <= start;
      lctr_q  <= clk_length_ctr;
      active  <= active_nxt;
    end
  end

  // Pointer, divider, length counter and sample buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      div        <= '0;
      len_cnt    <= '0;
      sample_buf <= '0;
    end else if (trig) begin
      ptr     <= '0;
      div     <= reload;
      len_cnt <= len_load;
    end else begin
      if (active)
        div <= (&div) ? reload : div + 1'b1;
      if (step) begin
        ptr        <= nxt_ptr;
        sample_buf <= new_sample;
      end
      if (len_dec)
        len_cnt <= len_cnt - 1'b1;
    end
  end

  // Wave RAM; CPU writes only land while the channel is idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB; i++)
        ram[i] <= '0;
    end else if (cpu_we && !active) begin
      ram[cpu_addr] <= cpu_wdata;
    end
  end

  // Output level with volume shift
  always_comb begin
    vshift = volume - 2'd1;
    level  = '0;
    if (active && dac_on && volume != 2'b00)
      level = sample_buf >> vshift;
  end

  assign cpu_rdata = active ? 8'hFF : ram[cpu_addr];
  assign position  = ptr;
  assign enable    = active;

endmodule
